// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer
//   Pixel-generation stage between the VGA timing generator and the pins.
//   Each timer sample is registered into S1, addresses screen memory to fetch
//   a tile code, combines that code with the in-tile pixel offset to address
//   bitmap memory, and emits the fetched 12-bit colour. hsync/vsync travel
//   down the same pipeline, so they stay aligned with RGB.
//
// Ports
//   clk, reset_n              pixel clock; asynchronous active-low reset
//   x, y, activevideo         pixel position and visible flag from the timer
//   hsync_in, vsync_in        syncs from the timer
//   smem_addr / smem_data     screen-memory read port (code valid 1 cycle later)
//   bmem_addr / bmem_data     bitmap read port {code, ylo, xlo} -> {R,G,B}
//   red, green, blue          registered pixel colour, 0 while blanking
//   hsync, vsync              registered syncs, aligned with RGB
//   frame_tick                1-cycle pulse after output vsync returns idle
module vga_tile_renderer #(
    parameter int   XBITS      = 10,
    parameter int   YBITS      = 10,
    parameter int   TILE_LOG2  = 4,
    parameter int   COLS       = 40,
    parameter int   ROWS       = 30,
    parameter int   SMEM_ABITS = 11,
    parameter int   CODE_BITS  = 4,
    parameter logic SYNC_IDLE  = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [XBITS-1:0]                 x,
    input  logic [YBITS-1:0]                 y,
    input  logic                             activevideo,
    input  logic                             hsync_in,
    input  logic                             vsync_in,
    output logic [SMEM_ABITS-1:0]            smem_addr,
    input  logic [CODE_BITS-1:0]             smem_data,
    output logic [CODE_BITS+2*TILE_LOG2-1:0] bmem_addr,
    input  logic [11:0]                      bmem_data,
    output logic [3:0]                       red,
    output logic [3:0]                       green,
    output logic [3:0]                       blue,
    output logic                             hsync,
    output logic                             vsync,
    output logic                             frame_tick
);

    // S1: full timer sample
    logic [XBITS-1:0]     s1_x_q, s1_x_d;
    logic [YBITS-1:0]     s1_y_q, s1_y_d;
    logic                 s1_active_q, s1_active_d;
    logic                 s1_hsync_q, s1_hsync_d;
    logic                 s1_vsync_q, s1_vsync_d;
    // S2: in-tile offset, waits for the tile code
    logic [TILE_LOG2-1:0] s2_xlo_q, s2_xlo_d;
    logic [TILE_LOG2-1:0] s2_ylo_q, s2_ylo_d;
    logic                 s2_active_q, s2_active_d;
    logic                 s2_hsync_q, s2_hsync_d;
    logic                 s2_vsync_q, s2_vsync_d;
    // S3: waits for the bitmap colour
    logic                 s3_active_q, s3_active_d;
    logic                 s3_hsync_q, s3_hsync_d;
    logic                 s3_vsync_q, s3_vsync_d;
    // Output registers
    logic [11:0]          rgb_q, rgb_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic                 vsync_prev_q, vsync_prev_d;
    logic                 frame_tick_q, frame_tick_d;

    logic [XBITS-TILE_LOG2-1:0] tile_col;
    logic [YBITS-TILE_LOG2-1:0] tile_row;
    logic                       tile_in_range;

    // Screen-memory address from S1. Blanking (or a tile outside the
    // visible grid) parks the address at 0 so timer coordinates in the
    // porches never reach memory.
    always_comb begin
        tile_col      = s1_x_q[XBITS-1:TILE_LOG2];
        tile_row      = s1_y_q[YBITS-1:TILE_LOG2];
        tile_in_range = (32'(tile_col) < COLS) && (32'(tile_row) < ROWS);
        if (s1_active_q && tile_in_range) begin
            smem_addr = SMEM_ABITS'(32'(tile_row) * COLS + 32'(tile_col));
        end else begin
            smem_addr = '0;
        end
    end

    // Bitmap address: tile code just returned by screen memory plus the
    // pixel offset that travelled alongside it.
    assign bmem_addr = {smem_data, s2_ylo_q, s2_xlo_q};

    always_comb begin
        s1_x_d       = x;
        s1_y_d       = y;
        s1_active_d  = activevideo;
        s1_hsync_d   = hsync_in;
        s1_vsync_d   = vsync_in;

        s2_xlo_d     = s1_x_q[TILE_LOG2-1:0];
        s2_ylo_d     = s1_y_q[TILE_LOG2-1:0];
        s2_active_d  = s1_active_q;
        s2_hsync_d   = s1_hsync_q;
        s2_vsync_d   = s1_vsync_q;

        s3_active_d  = s2_active_q;
        s3_hsync_d   = s2_hsync_q;
        s3_vsync_d   = s2_vsync_q;

        rgb_d        = s3_active_q ? bmem_data : '0;
        hsync_d      = s3_hsync_q;
        vsync_d      = s3_vsync_q;

        // Pulse on the cycle after output vsync has gone back to idle.
        vsync_prev_d = vsync_q;
        frame_tick_d = (vsync_q == SYNC_IDLE) && (vsync_prev_q != SYNC_IDLE);
    end

    // Sync bits in every stage reset to the idle level so that the cycles
    // draining out after reset release show idle syncs, not a false pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_active_q  <= 1'b0;
            s1_hsync_q   <= SYNC_IDLE;
            s1_vsync_q   <= SYNC_IDLE;
            s2_xlo_q     <= '0;
            s2_ylo_q     <= '0;
            s2_active_q  <= 1'b0;
            s2_hsync_q   <= SYNC_IDLE;
            s2_vsync_q   <= SYNC_IDLE;
            s3_active_q  <= 1'b0;
            s3_hsync_q   <= SYNC_IDLE;
            s3_vsync_q   <= SYNC_IDLE;
            rgb_q        <= '0;
            hsync_q      <= SYNC_IDLE;
            vsync_q      <= SYNC_IDLE;
            vsync_prev_q <= SYNC_IDLE;
            frame_tick_q <= 1'b0;
        end else begin
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s1_active_q  <= s1_active_d;
            s1_hsync_q   <= s1_hsync_d;
            s1_vsync_q   <= s1_vsync_d;
            s2_xlo_q     <= s2_xlo_d;
            s2_ylo_q     <= s2_ylo_d;
            s2_active_q  <= s2_active_d;
            s2_hsync_q   <= s2_hsync_d;
            s2_vsync_q   <= s2_vsync_d;
            s3_active_q  <= s3_active_d;
            s3_hsync_q   <= s3_hsync_d;
            s3_vsync_q   <= s3_vsync_d;
            rgb_q        <= rgb_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            vsync_prev_q <= vsync_prev_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Testbench for vga_tile_renderer: synchronous RAM models for screen and
// bitmap memory, plus a reference model computing each pixel's colour
// directly from tile arithmetic and memory contents.
module tb_vga_tile_renderer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        activevideo = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [10:0] smem_addr;
    logic [3:0]  smem_data = '0;
    logic [11:0] bmem_addr;
    logic [11:0] bmem_data = '0;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync, frame_tick;

    int checks = 0;
    int failures = 0;

    vga_tile_renderer #(
        .XBITS(10), .YBITS(10), .TILE_LOG2(4), .COLS(40), .ROWS(30),
        .SMEM_ABITS(11), .CODE_BITS(4), .SYNC_IDLE(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .activevideo(activevideo),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .smem_addr(smem_addr), .smem_data(smem_data),
        .bmem_addr(bmem_addr), .bmem_data(bmem_data),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Memory models: synchronous read, one cycle latency.
    logic [3:0]  smem_m [0:2047];
    logic [11:0] bmem_m [0:4095];
    always @(posedge clk) begin
        smem_data <= smem_m[smem_addr];
        bmem_data <= bmem_m[bmem_addr];
    end

    // Reference model state.
    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } out_t;
    out_t        exp_q[$];
    logic [9:0]  prev_x, prev_y;
    logic        prev_a;
    logic        hist1, hist2;
    out_t        e_out;
    logic [10:0] e_smem;
    logic [11:0] e_bmem;
    logic        e_tick;

    function automatic int unsigned tile_index(input logic [9:0] xi, input logic [9:0] yi,
                                               input logic ai);
        return ai ? (int'(yi) / 16) * 40 + int'(xi) / 16 : 0;
    endfunction

    // Model state right after reset: three stages plus output hold a blank,
    // idle-sync pixel; previous sample is a blank at the origin.
    task automatic model_reset();
        exp_q.delete();
        repeat (3) exp_q.push_back({12'h000, 1'b1, 1'b1});
        prev_x = '0; prev_y = '0; prev_a = 1'b0;
        hist1 = 1'b1; hist2 = 1'b1;
    endtask

    // Present one timer sample, clock it in, and compute what the DUT
    // should show #1 after that edge.
    task automatic step(input logic [9:0] xi, input logic [9:0] yi, input logic ai,
                        input logic hi, input logic vi);
        int unsigned idx, pidx;
        out_t e;
        x = xi; y = yi; activevideo = ai; hsync_in = hi; vsync_in = vi;
        @(posedge clk);
        idx   = tile_index(xi, yi, ai);
        pidx  = tile_index(prev_x, prev_y, prev_a);
        e.rgb = ai ? bmem_m[{smem_m[idx], yi[3:0], xi[3:0]}] : 12'h000;
        e.hs  = hi;
        e.vs  = vi;
        exp_q.push_back(e);
        e_out  = exp_q.pop_front();
        e_smem = idx[10:0];
        e_bmem = {smem_m[pidx], prev_y[3:0], prev_x[3:0]};
        e_tick = hist1 && !hist2;
        hist2 = hist1;
        hist1 = e_out.vs;
        prev_x = xi; prev_y = yi; prev_a = ai;
        #1;
    endtask

    task automatic flush();
        repeat (4) step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 2048; i++) smem_m[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 4096; i++) bmem_m[i] = 12'($urandom);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if ({red, green, blue, hsync, vsync, frame_tick, smem_addr} !== {12'h000, 1'b1, 1'b1, 1'b0, 11'd0}) begin
            failures++;
            $display("FAIL reset_state got rgb=%h hs=%b vs=%b tick=%b smem=%0d exp rgb=000 hs=1 vs=1 tick=0 smem=0",
                     {red, green, blue}, hsync, vsync, frame_tick, smem_addr);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        // Four blank idle cycles drain out after release.
        for (int i = 0; i < 4; i++) begin
            step(10'd5, 10'd5, 1'b1, 1'b0, 1'b0);
            if (i < 3) begin
                checks++;
                if ({red, green, blue, hsync, vsync} !== {12'h000, 1'b1, 1'b1}) begin
                    failures++;
                    $display("FAIL reset_drain[%0d] got=%h exp=%h", i, {red, green, blue, hsync, vsync}, {12'h000, 1'b1, 1'b1});
                end
            end
        end
        flush();
    endtask

    task automatic test_origin_pixel();
        smem_m[0] = 4'h3;
        bmem_m[12'h300] = 12'hF80;
        step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (smem_addr !== 11'd0) begin
            failures++;
            $display("FAIL origin_smem got=%0d exp=0", smem_addr);
        end
        step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bmem_addr !== 12'h300) begin
            failures++;
            $display("FAIL origin_bmem got=%h exp=300", bmem_addr);
        end
        step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({red, green, blue} !== 12'hF80) begin
            failures++;
            $display("FAIL origin_rgb got=%h exp=F80", {red, green, blue});
        end
        flush();
    endtask

    task automatic test_last_pixel();
        step(10'd639, 10'd479, 1'b1, 1'b1, 1'b1);
        checks++;
        if (smem_addr !== 11'd1199) begin
            failures++;
            $display("FAIL last_smem got=%0d exp=1199", smem_addr);
        end
        step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bmem_addr[7:0] !== 8'hFF) begin
            failures++;
            $display("FAIL last_bmem_low got=%h exp=FF", bmem_addr[7:0]);
        end
        step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({red, green, blue} !== e_out.rgb) begin
            failures++;
            $display("FAIL last_rgb got=%h exp=%h", {red, green, blue}, e_out.rgb);
        end
        flush();
    endtask

    task automatic test_blanking();
        for (int i = 0; i < 4096; i++) bmem_m[i] = 12'hFFF;
        step(10'd700, 10'd10, 1'b0, 1'b1, 1'b1);
        checks++;
        if (smem_addr !== 11'd0) begin
            failures++;
            $display("FAIL blank_smem got=%0d exp=0", smem_addr);
        end
        for (int i = 0; i < 3; i++) step(10'd799, 10'd524, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            failures++;
            $display("FAIL blank_rgb got=%h exp=000", {red, green, blue});
        end
        checks++;
        if (smem_addr !== 11'd0) begin
            failures++;
            $display("FAIL blank_oob_smem got=%0d exp=0", smem_addr);
        end
        flush();
        fill_random();
    endtask

    task automatic test_hsync_width();
        int low_cnt = 0;
        int first_low = -1;
        for (int i = 1; i <= 130; i++) begin
            step(10'(650 + (i % 100)), 10'd100, 1'b0, !(i >= 11 && i < 107), 1'b1);
            checks++;
            if (hsync !== e_out.hs) begin
                failures++;
                $display("FAIL hsync_step[%0d] got=%b exp=%b", i, hsync, e_out.hs);
            end
            if (hsync === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = i;
            end
        end
        checks++;
        if (low_cnt != 96) begin
            failures++;
            $display("FAIL hsync_width got=%0d exp=96", low_cnt);
        end
        checks++;
        if (first_low != 14) begin
            failures++;
            $display("FAIL hsync_start got=%0d exp=14", first_low);
        end
    endtask

    task automatic test_random();
        logic [9:0] xi, yi;
        logic       ai;
        for (int i = 0; i < 400; i++) begin
            ai = 1'($urandom_range(0, 1));
            xi = ai ? 10'($urandom_range(0, 639)) : 10'($urandom);
            yi = ai ? 10'($urandom_range(0, 479)) : 10'($urandom);
            step(xi, yi, ai, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
            checks++;
            if (smem_addr !== e_smem) begin
                failures++;
                $display("FAIL rand_smem[%0d] got=%0d exp=%0d", i, smem_addr, e_smem);
            end
            checks++;
            if (bmem_addr !== e_bmem) begin
                failures++;
                $display("FAIL rand_bmem[%0d] got=%h exp=%h", i, bmem_addr, e_bmem);
            end
            checks++;
            if ({red, green, blue, hsync, vsync} !== e_out) begin
                failures++;
                $display("FAIL rand_out[%0d] got=%h exp=%h", i, {red, green, blue, hsync, vsync}, e_out);
            end
            checks++;
            if (frame_tick !== e_tick) begin
                failures++;
                $display("FAIL rand_tick[%0d] got=%b exp=%b", i, frame_tick, e_tick);
            end
        end
        flush();
    endtask

    // Compressed timer (40x20 total, 24x12 visible) so two whole frames
    // fit in a short run; the pipeline is indifferent to frame geometry.
    task automatic test_frames();
        int ticks = 0;
        logic a, hs, vs;
        for (int f = 0; f < 2; f++) begin
            for (int yy = 0; yy < 20; yy++) begin
                for (int xx = 0; xx < 40; xx++) begin
                    a  = (xx < 24) && (yy < 12);
                    hs = !(xx >= 28 && xx < 32);
                    vs = !(yy >= 14 && yy < 16);
                    step(10'(xx), 10'(yy), a, hs, vs);
                    if (frame_tick === 1'b1) ticks++;
                    checks++;
                    if ({red, green, blue, hsync, vsync} !== e_out) begin
                        failures++;
                        $display("FAIL frame_out[%0d,%0d,%0d] got=%h exp=%h", f, yy, xx, {red, green, blue, hsync, vsync}, e_out);
                    end
                    checks++;
                    if (frame_tick !== e_tick) begin
                        failures++;
                        $display("FAIL frame_tick[%0d,%0d,%0d] got=%b exp=%b", f, yy, xx, frame_tick, e_tick);
                    end
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
            if (frame_tick === 1'b1) ticks++;
        end
        checks++;
        if (ticks != 2) begin
            failures++;
            $display("FAIL frame_tick_count got=%0d exp=2", ticks);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 6; i++)
            step(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), 1'b1, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({red, green, blue, hsync, vsync, frame_tick, smem_addr} !== {12'h000, 1'b1, 1'b1, 1'b0, 11'd0}) begin
            failures++;
            $display("FAIL midreset_state got rgb=%h hs=%b vs=%b tick=%b smem=%0d exp rgb=000 hs=1 vs=1 tick=0 smem=0",
                     {red, green, blue}, hsync, vsync, frame_tick, smem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 30; i++) begin
            step(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), 1'b1,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            checks++;
            if ({red, green, blue, hsync, vsync} !== e_out) begin
                failures++;
                $display("FAIL midreset_out[%0d] got=%h exp=%h", i, {red, green, blue, hsync, vsync}, e_out);
            end
            checks++;
            if (frame_tick !== e_tick) begin
                failures++;
                $display("FAIL midreset_tick[%0d] got=%b exp=%b", i, frame_tick, e_tick);
            end
        end
        flush();
    endtask

    initial begin
        fill_random();
        model_reset();
        test_reset();
        test_origin_pixel();
        test_last_pixel();
        test_blanking();
        test_hsync_width();
        test_random();
        test_frames();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
